// File: rtl/child_rr_sequencer_pkg.sv
// Shared types and helpers for the child round-robin grant sequencer.
// The reference pick function scans at most 16 requesters, the widest legal configuration.
package child_seq_pkg;

   localparam int TIMEOUT_CNT_W = 8;
   localparam int PICK_MAX      = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } seq_state_t;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } pick_t;

   // First set request scanning ptr, ptr+1, ... with wrap at num_req.
   function automatic pick_t rr_pick(input logic [PICK_MAX-1:0] req,
                                     input logic [3:0]          ptr,
                                     input int                  num_req);
      pick_t res;
      int    k;
      res = '0;
      for (int i = num_req - 1; i >= 0; i--) begin
         k = int'(ptr) + i;
         if (k >= num_req) k = k - num_req;
         if (req[k[3:0]]) begin
            res.found = 1'b1;
            res.idx   = k[3:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/child_rr_sequencer_if.sv
// Request/grant bundle between the child instances (master) and the sequencer (slave).
interface child_rr_sequencer_if
   import child_seq_pkg::*;
   #(parameter int NUM_REQ = 5,
     localparam int IDX_W = $clog2(NUM_REQ));

   logic                     en;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ-1:0]       gnt;
   logic                     gnt_valid;
   logic [IDX_W-1:0]         gnt_idx;
   logic                     timeout;
   logic [TIMEOUT_CNT_W-1:0] timeout_cnt;
   logic                     busy;

   modport master (
      output en, req,
      input  gnt, gnt_valid, gnt_idx, timeout, timeout_cnt, busy
   );

   modport slave (
      input  en, req,
      output gnt, gnt_valid, gnt_idx, timeout, timeout_cnt, busy
   );

endinterface

// File: rtl/child_rr_sequencer_rr_priority_pick.sv
// Combinational round-robin pick: rotate requests so ptr lands on bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_priority_pick
   import child_seq_pkg::*;
   #(parameter int NUM_REQ = 5,
     localparam int IDX_W = $clog2(NUM_REQ))
   (
      input  logic [NUM_REQ-1:0] req,
      input  logic [IDX_W-1:0]   ptr,
      output logic               found,
      output logic [IDX_W-1:0]   idx
   );

   localparam logic [IDX_W:0] NUM_REQ_EXT = (IDX_W+1)'(NUM_REQ);

   logic [2*NUM_REQ-1:0] doubled;
   logic [NUM_REQ-1:0]   rotated;
   logic [IDX_W-1:0]     offset;
   logic [IDX_W:0]       sum;
   logic [PICK_MAX-1:0]  req_ext;
   pick_t                chk;

   assign doubled = {req, req};
   assign rotated = NUM_REQ'(doubled >> ptr);

   // The scan-based package function cross-checks the rotate/encode result.
   always_comb begin
      found  = 1'b0;
      offset = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            found  = 1'b1;
            offset = IDX_W'(i);
         end
      end
      sum = {1'b0, ptr} + {1'b0, offset};
      if (sum >= NUM_REQ_EXT) sum = sum - NUM_REQ_EXT;
      idx = sum[IDX_W-1:0];

      req_ext              = '0;
      req_ext[NUM_REQ-1:0] = req;
      chk                  = rr_pick(req_ext, 4'(ptr), NUM_REQ);
      assert (chk.found == found && (!found || chk.idx == 4'(idx)));
   end

endmodule

// File: rtl/child_rr_sequencer.sv
// Round-robin sequencer sharing one resource slot among NUM_REQ children,
// with a hold-limit watchdog and a mandatory dead cycle between grants.
module child_rr_sequencer
   import child_seq_pkg::*;
   #(parameter int NUM_REQ  = 5,
     parameter int MAX_HOLD = 16,
     localparam int IDX_W = $clog2(NUM_REQ))
   (
      input  logic                 clk,
      input  logic                 rst,
      child_rr_sequencer_if.slave  bus
   );

   localparam logic [7:0]         HOLD_LAST = 8'(MAX_HOLD - 1);
   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] GNT_ONE   = {{(NUM_REQ-1){1'b0}}, 1'b1};

   seq_state_t               state, state_next;
   logic [IDX_W-1:0]         ptr, ptr_next;
   logic [7:0]               hold_cnt, hold_next;
   logic [NUM_REQ-1:0]       gnt_r, gnt_next;
   logic [IDX_W-1:0]         gnt_idx_r, gnt_idx_next;
   logic                     timeout_r, timeout_next;
   logic [TIMEOUT_CNT_W-1:0] tcnt_r, tcnt_next;

   logic                     pick_found;
   logic [IDX_W-1:0]         pick_idx;
   logic                     grant_start, normal_rel, forced_rel;

   rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req   (bus.req),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Only the granted child's request matters while a grant is live.
   always_comb begin
      state_next  = state;
      grant_start = 1'b0;
      normal_rel  = 1'b0;
      forced_rel  = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.en && pick_found) begin
               grant_start = 1'b1;
               state_next  = GRANT;
            end
         end
         GRANT: begin
            if (!bus.req[gnt_idx_r]) begin
               normal_rel = 1'b1;
               state_next = GAP;
            end else if (hold_cnt == HOLD_LAST) begin
               forced_rel = 1'b1;
               state_next = GAP;
            end
         end
         GAP:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      gnt_next     = gnt_r;
      gnt_idx_next = gnt_idx_r;
      ptr_next     = ptr;
      hold_next    = hold_cnt;
      timeout_next = 1'b0;
      tcnt_next    = tcnt_r;
      if (grant_start) begin
         gnt_next     = GNT_ONE << pick_idx;
         gnt_idx_next = pick_idx;
         hold_next    = '0;
      end else if (normal_rel || forced_rel) begin
         gnt_next = '0;
         ptr_next = (gnt_idx_r == LAST_IDX) ? '0 : gnt_idx_r + 1'b1;
      end else if (state == GRANT) begin
         hold_next = hold_cnt + 1'b1;
      end
      if (forced_rel) begin
         timeout_next = 1'b1;
         if (tcnt_r != '1) tcnt_next = tcnt_r + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         hold_cnt  <= '0;
         gnt_r     <= '0;
         gnt_idx_r <= '0;
         timeout_r <= 1'b0;
         tcnt_r    <= '0;
      end else begin
         ptr       <= ptr_next;
         hold_cnt  <= hold_next;
         gnt_r     <= gnt_next;
         gnt_idx_r <= gnt_idx_next;
         timeout_r <= timeout_next;
         tcnt_r    <= tcnt_next;
      end
   end

   assign bus.gnt         = gnt_r;
   assign bus.gnt_valid   = |gnt_r;
   assign bus.gnt_idx     = gnt_idx_r;
   assign bus.timeout     = timeout_r;
   assign bus.timeout_cnt = tcnt_r;
   assign bus.busy        = (state != IDLE);

   a_onehot:  assert property (@(posedge clk) $onehot0(gnt_r));
   a_valid:   assert property (@(posedge clk) bus.gnt_valid == (|gnt_r));
   a_gnt_st:  assert property (@(posedge clk) (|gnt_r) |-> (state == GRANT));
   a_timeout: assert property (@(posedge clk) timeout_r |-> $past(forced_rel && !rst));

endmodule

// File: tb/tb_child_rr_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations, then a
// randomized phase, all checked every cycle against a behavioural model.
module tb_child_rr_sequencer;

   localparam int NUM_REQ  = 5;
   localparam int MAX_HOLD = 16;

   logic clk;
   logic rst;

   child_rr_sequencer_if #(.NUM_REQ(NUM_REQ)) bus ();

   child_rr_sequencer #(.NUM_REQ(NUM_REQ), .MAX_HOLD(MAX_HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   int m_owner;
   int m_age;
   bit m_gap;
   int m_idx;
   int m_ptr;
   int m_tcnt;
   bit m_tpulse;
   bit model_ready = 1'b0;
   int m_sel;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic e, input logic [NUM_REQ-1:0] q);
      rst     = r;
      bus.en  = e;
      bus.req = q;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Model: an owner with an age in cycles, a one-cycle cooldown, and a rotating start point.
   always @(posedge clk) begin
      if (rst) begin
         m_owner     = -1;
         m_age       = 0;
         m_gap       = 1'b0;
         m_idx       = 0;
         m_ptr       = 0;
         m_tcnt      = 0;
         m_tpulse    = 1'b0;
         model_ready = 1'b1;
      end else if (model_ready) begin
         m_tpulse = 1'b0;
         if (m_owner >= 0) begin
            if (!bus.req[m_owner] || m_age == MAX_HOLD) begin
               if (bus.req[m_owner]) begin
                  m_tpulse = 1'b1;
                  if (m_tcnt < 255) m_tcnt++;
               end
               m_ptr   = (m_owner + 1) % NUM_REQ;
               m_owner = -1;
               m_gap   = 1'b1;
            end else begin
               m_age++;
            end
         end else if (m_gap) begin
            m_gap = 1'b0;
         end else if (bus.en && bus.req != '0) begin
            m_sel = -1;
            for (int k = NUM_REQ - 1; k >= 0; k--)
               if (bus.req[(m_ptr + k) % NUM_REQ]) m_sel = (m_ptr + k) % NUM_REQ;
            m_owner = m_sel;
            m_idx   = m_sel;
            m_age   = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (model_ready) begin
         checkOutput("gnt", 32'(bus.gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
         checkOutput("gnt_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
         checkOutput("gnt_idx", 32'(bus.gnt_idx), 32'(m_idx));
         checkOutput("timeout", 32'(bus.timeout), 32'(m_tpulse));
         checkOutput("timeout_cnt", 32'(bus.timeout_cnt), 32'(m_tcnt));
         checkOutput("busy", 32'(bus.busy), 32'((m_owner >= 0) || m_gap));
      end
   end

   int order[$];
   int lens[$];
   int exp_order[6] = '{0, 1, 2, 3, 4, 0};
   int run;
   int pulses;
   bit prev_valid;
   logic [NUM_REQ-1:0] rq;
   logic               re;
   logic               rr;

   initial begin
      $display("[TB] starting child_rr_sequencer bench");

      // Reset with all requests high, then first grant goes to child 0.
      repeat (3) applyStimulus(1'b1, 1'b1, 5'b11111);
      checkOutput("lit_reset_gnt", 32'(bus.gnt), 32'd0);
      checkOutput("lit_reset_idx", 32'(bus.gnt_idx), 32'd0);
      checkOutput("lit_reset_tcnt", 32'(bus.timeout_cnt), 32'd0);
      checkOutput("lit_reset_busy", 32'(bus.busy), 32'd0);
      applyStimulus(1'b0, 1'b1, 5'b11111);
      checkOutput("lit_first_gnt", 32'(bus.gnt), 32'b00001);
      applyStimulus(1'b0, 1'b1, 5'b00000);
      applyStimulus(1'b0, 1'b1, 5'b00000);

      // Single request held for four cycles.
      applyStimulus(1'b0, 1'b1, 5'b00100);
      checkOutput("lit_single_gnt", 32'(bus.gnt), 32'b00100);
      checkOutput("lit_single_idx", 32'(bus.gnt_idx), 32'd2);
      repeat (3) applyStimulus(1'b0, 1'b1, 5'b00100);
      checkOutput("lit_single_held", 32'(bus.gnt), 32'b00100);
      applyStimulus(1'b0, 1'b1, 5'b00000);
      checkOutput("lit_gap_gnt", 32'(bus.gnt), 32'd0);
      checkOutput("lit_gap_busy", 32'(bus.busy), 32'd1);
      applyStimulus(1'b0, 1'b1, 5'b00000);
      checkOutput("lit_idle_busy", 32'(bus.busy), 32'd0);
      checkOutput("lit_idle_idx_hold", 32'(bus.gnt_idx), 32'd2);
      applyStimulus(1'b0, 1'b1, 5'b11111);
      checkOutput("lit_next_from_ptr3", 32'(bus.gnt_idx), 32'd3);

      // Round-robin wrap with every request held high.
      repeat (2) applyStimulus(1'b1, 1'b1, 5'b00000);
      run = 0; pulses = 0; prev_valid = 1'b0;
      for (int c = 0; c < 5 * (MAX_HOLD + 2) + 1; c++) begin
         applyStimulus(1'b0, 1'b1, 5'b11111);
         if (bus.gnt_valid && !prev_valid) order.push_back(int'(bus.gnt_idx));
         if (bus.gnt_valid) run++;
         else if (prev_valid) begin
            lens.push_back(run);
            run = 0;
         end
         if (bus.timeout) pulses++;
         prev_valid = bus.gnt_valid;
      end
      checkOutput("lit_rr_count", 32'(order.size()), 32'd6);
      for (int i = 0; i < order.size() && i < 6; i++) checkOutput("lit_rr_order", 32'(order[i]), 32'(exp_order[i]));
      checkOutput("lit_rr_lens", 32'(lens.size()), 32'd5);
      foreach (lens[i]) checkOutput("lit_rr_len", 32'(lens[i]), 32'(MAX_HOLD));
      checkOutput("lit_rr_pulses", 32'(pulses), 32'd5);
      checkOutput("lit_rr_tcnt", 32'(bus.timeout_cnt), 32'd5);

      // Pointer skip: with ptr at 3, requests 0 and 1 pick 0.
      repeat (2) applyStimulus(1'b1, 1'b1, 5'b00000);
      applyStimulus(1'b0, 1'b1, 5'b00100);
      applyStimulus(1'b0, 1'b1, 5'b00000);
      applyStimulus(1'b0, 1'b1, 5'b00000);
      applyStimulus(1'b0, 1'b1, 5'b00011);
      checkOutput("lit_skip_idx", 32'(bus.gnt_idx), 32'd0);
      checkOutput("lit_skip_gnt", 32'(bus.gnt), 32'b00001);
      repeat (2) applyStimulus(1'b0, 1'b1, 5'b00000);

      // Enable gating, and a grant that outlives en being dropped.
      repeat (10) applyStimulus(1'b0, 1'b0, 5'b01000);
      checkOutput("lit_en_off_gnt", 32'(bus.gnt), 32'd0);
      applyStimulus(1'b0, 1'b1, 5'b01000);
      checkOutput("lit_en_on_gnt", 32'(bus.gnt), 32'b01000);
      repeat (MAX_HOLD - 1) applyStimulus(1'b0, 1'b0, 5'b01000);
      checkOutput("lit_en_drop_held", 32'(bus.gnt), 32'b01000);
      applyStimulus(1'b0, 1'b0, 5'b01000);
      checkOutput("lit_en_drop_timeout", 32'(bus.timeout), 32'd1);
      repeat (3) applyStimulus(1'b0, 1'b0, 5'b01000);
      checkOutput("lit_en_off_again", 32'(bus.gnt), 32'd0);

      // Reset in the middle of a grant.
      applyStimulus(1'b0, 1'b1, 5'b00010);
      checkOutput("lit_mid_idx", 32'(bus.gnt_idx), 32'd1);
      repeat (7) applyStimulus(1'b0, 1'b1, 5'b00010);
      applyStimulus(1'b1, 1'b1, 5'b00010);
      checkOutput("lit_mid_gnt", 32'(bus.gnt), 32'd0);
      checkOutput("lit_mid_timeout", 32'(bus.timeout), 32'd0);
      checkOutput("lit_mid_tcnt", 32'(bus.timeout_cnt), 32'd0);
      applyStimulus(1'b0, 1'b1, 5'b11111);
      checkOutput("lit_mid_ptr0", 32'(bus.gnt_idx), 32'd0);

      // Saturate the forced-release counter.
      repeat (260 * (MAX_HOLD + 2)) applyStimulus(1'b0, 1'b1, 5'b11111);
      checkOutput("lit_sat_tcnt", 32'(bus.timeout_cnt), 32'd255);

      // Randomized traffic with sticky requests and rare resets.
      rq = 5'b00000; re = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) rq = NUM_REQ'($urandom_range(0, 31));
         if ($urandom_range(0, 15) == 0) re = ($urandom_range(0, 3) != 0);
         rr = ($urandom_range(0, 199) == 0);
         applyStimulus(rr, re, rq);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/child_rr_sequencer.md
Name: child_rr_sequencer

Overview:
- Round-robin grant sequencer that shares one common resource slot among the NUM_REQ child instances of a root module (default 5, inst_0..inst_4).
- Each child raises a request; the block grants exactly one child at a time.
- A grant is held until the child releases it or a hold-limit watchdog forces release.
- Sits in the root module, between the child instances and the shared resource.

Parameters:
- NUM_REQ, 5, number of requesting child instances (legal range 2..16).
- MAX_HOLD, 16, maximum consecutive cycles a grant may be held (legal range 2..255).
- IDX_W, $clog2(NUM_REQ), width of the grant index (derived; do not override).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  when low, no new grant is issued; an existing grant runs to completion.
- req  in  NUM_REQ  per-child request, level-sensitive.
- gnt  out  NUM_REQ  one-hot grant, registered.
- gnt_valid  out  1  high while any grant is active (equals |gnt).
- gnt_idx  out  IDX_W  index of the granted child; holds its last value when idle.
- timeout  out  1  one-cycle pulse when a grant is force-released by the watchdog.
- timeout_cnt  out  8  saturating count of forced releases.
- busy  out  1  high in states GRANT and GAP.

Behaviour:
- Reset (synchronous, rst high at clock edge):
  - gnt=0, gnt_valid=0, gnt_idx=0, timeout=0, timeout_cnt=0, busy=0.
  - Priority pointer ptr=0; hold_cnt=0; state=IDLE.
  - Reset asserted mid-grant drops gnt on the very next edge; no timeout pulse and no ptr advance.
- State IDLE:
  - If en=1 and req!=0, select the first set req bit scanning ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
  - On the next edge: gnt=onehot(sel), gnt_idx=sel, hold_cnt=0, state=GRANT.
  - Latency from req to gnt: exactly 1 cycle.
  - Otherwise stay in IDLE; outputs unchanged.
- State GRANT (each cycle):
  - If req[gnt_idx]=0, this is a normal release.
  - Else if hold_cnt==MAX_HOLD-1, this is a forced release: timeout=1 for one cycle; timeout_cnt increments and saturates at 255.
  - Else hold_cnt increments and the grant is held.
  - On either release: gnt=0 next edge, ptr=(gnt_idx==NUM_REQ-1)?0:gnt_idx+1, state=GAP.
  - Max grant duration is MAX_HOLD cycles.
  - Changes on other req bits are ignored during GRANT.
- State GAP:
  - Exactly one dead cycle with gnt=0 and busy=1; then state=IDLE.
  - Guarantees at least one idle cycle between consecutive grants.
  - Arbitration resumes in IDLE, so back-to-back grants occur every hold+2 cycles minimum.
- en deasserted during GRANT or GAP has no effect until IDLE; while in IDLE with en=0, no grant is issued.
- Invariants, checked by assertion:
  - $onehot0(gnt) at all times.
  - gnt_valid == |gnt.
  - gnt only set in GRANT.
  - timeout only asserted in the cycle following a forced release decision.
- Fairness: with every req held high permanently, grants cycle 0,1,2,3,4,0,... and each lasts MAX_HOLD cycles.

Decomposition:
- Shared package child_seq_pkg holds:
  - state enum typedef {IDLE, GRANT, GAP} (2-bit).
  - TIMEOUT_CNT_W=8 constant.
  - Function rr_pick(req, ptr), returning the selected index and a found flag.
- One sub-module, rr_priority_pick: purely combinational rotate/priority-encode/unrotate, parameterised by NUM_REQ.
- The FSM, counters and output registers live in child_rr_sequencer.

Test Plan:
- Reset and idle: rst high 3 cycles with req=5'b11111 → gnt=0, gnt_idx=0, timeout_cnt=0; after rst drops, gnt=5'b00001 one cycle later.
- Single request: req=5'b00100 for 4 cycles, then 0 → gnt=5'b00100 for 4 cycles, gnt_idx=2, then one GAP cycle with busy=1, then IDLE; next grant starts from ptr=3.
- Round-robin wrap: all req high, MAX_HOLD=16 → grant order 0,1,2,3,4,0; each grant 16 cycles; 5 timeout pulses; timeout_cnt=5.
- Pointer skip: ptr=3, req=5'b00011 → grant index 0 (wrap past 3 and 4), not 1.
- en gating: en=0 with req=5'b01000 for 10 cycles → no grant; en=1 → gnt=5'b01000 one cycle later. Dropping en mid-grant does not shorten the grant.
- Reset mid-grant and saturation:
  - rst asserted at hold_cnt=7 → gnt=0 next edge, ptr=0, no timeout pulse.
  - Separately, force 260 timeouts → timeout_cnt stays at 255.
